multi_channel_pwm: RTL and testbench
====================================

MULTI_CHANNEL_PWM -- requirements
Module: multi_channel_pwm

Interface
REQ-001 Parameter NUM_CH, default 4, number of PWM channels sharing one period counter.
REQ-002 Parameter CNT_W, default 16, width of period/duty/counter values in ticks.
REQ-003 Parameter PRE_W, default 8, width of the clock prescaler value.
REQ-004 Clk_In  input  1  single clock; all logic rising-edge.
REQ-005 Reset_In  input  1  asynchronous, active-low reset.
REQ-006 PWM_Enable_In  input  1  run counter when high.
REQ-007 Cfg_Load_In  input  1  one-cycle strobe capturing all Cfg inputs into staging.
REQ-008 Cfg_Mode_In  input  1  0 = edge-aligned, 1 = center-aligned.
REQ-009 Cfg_Prescale_In  input  PRE_W  tick every Cfg_Prescale_In+1 clocks.
REQ-010 Cfg_Period_In  input  CNT_W  period P in ticks.
REQ-011 Cfg_Duty_In  input  NUM_CH*CNT_W  per-channel duty D, channel i at bits [i*CNT_W +: CNT_W].
REQ-012 Cfg_Invert_In  input  NUM_CH  per-channel output inversion.
REQ-013 Cfg_Busy_Out  output  1  staged config pending transfer to shadow.
REQ-014 Period_Start_Out  output  1  one-cycle pulse at start of each period.
REQ-015 PWM_Signal_Out  output  NUM_CH  PWM outputs.

Function
REQ-016 Cfg_Load_In SHALL copy all Cfg inputs to staging registers and set pending; a load while pending SHALL overwrite staging.
REQ-017 Enabled: staging SHALL transfer to shadow only on the tick where counter wraps to 0 (period boundary); pending clears same cycle.
REQ-018 Load coincident with boundary: boundary SHALL transfer prior staging, new values SHALL be captured and pending SHALL remain 1.
REQ-019 Disabled: pending staging SHALL transfer to shadow on the next clock.
REQ-020 Prescaler SHALL count 0..shadow prescale and issue one tick on wrap; tick every clock when prescale = 0.
REQ-021 Edge mode: counter SHALL advance 0,1,..,P-1,0 per tick (period P ticks).
REQ-022 Center mode: counter SHALL advance 0..P-1 up, then P-1..0 down, each end value held two ticks (period 2P ticks).
REQ-023 Channel active SHALL be (counter < D); D = 0 gives 0 %, D >= P gives 100 %.
REQ-024 P = 0 SHALL hold counter at 0 and all channels inactive; boundary transfers SHALL still occur every tick.
REQ-025 PWM_Signal_Out[i] SHALL be registered (active XOR shadow invert[i]), one clock after the counter value.
REQ-026 Period_Start_Out SHALL be registered and coincide with the output cycle reflecting counter 0 at period start.
REQ-027 Disabled: counter and prescaler SHALL be 0, Period_Start_Out 0, PWM_Signal_Out[i] = shadow invert[i] from next clock.
REQ-028 On enable rising, the first period SHALL start with the next tick, using shadow values then in place.
REQ-029 All width arithmetic SHALL be unsigned, no overflow beyond CNT_W/PRE_W.

Reset
REQ-030 Reset_In low SHALL immediately clear counter, prescaler, staging, shadow, pending; all outputs 0.
REQ-031 Reset mid-period SHALL discard pending config; after release block idles until enabled.

Structure
REQ-032 Package pwm_pkg SHALL hold the mode enum (PWM_EDGE, PWM_CENTER) and default NUM_CH/CNT_W/PRE_W constants.
REQ-033 Sub-module pwm_channel_compare (compare, invert, output register) SHALL be instantiated NUM_CH times by generate.

Verification
REQ-034 NUM_CH=4, prescale 0, P=200, D={150,70,0,255}, edge, invert 0 -> ch0 high 150/200 clk, ch1 70/200, ch2 always low, ch3 always high.
REQ-035 Same, invert=4'b0001 -> ch0 low 150 clk, high 50 clk per period; others unchanged.
REQ-036 Cfg_Load_In with ch1 D=120 at counter 50 -> current period ch1 stays 70, next period 120; Cfg_Busy_Out high from load to boundary.
REQ-037 Center mode P=100, D=25 -> period 200 clk, ch0 high 50 clk symmetric around counter 0, Period_Start_Out every 200 clk.
REQ-038 Prescale 3, P=200 edge -> Period_Start_Out every 800 clk, ch0 (D=150) high 600 clk.
REQ-039 Reset_In low mid-period with load pending -> outputs 0 at once, Cfg_Busy_Out 0; PWM_Enable_In low -> outputs = invert level next clk.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and default sizing for the multi-channel PWM block.
//   pwm_mode_e   - counter shape (edge-aligned saw / center-aligned triangle)
//   PWM_NUM_CH   - default channel count
//   PWM_CNT_W    - default width of period/duty/counter values (ticks)
//   PWM_PRE_W    - default width of the clock prescaler value
package pwm_pkg;

  localparam int PWM_NUM_CH = 4;
  localparam int PWM_CNT_W  = 16;
  localparam int PWM_PRE_W  = 8;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

endpackage

// File: rtl/pwm_channel_compare.sv
// pwm_channel_compare: one PWM lane. Compares the shared period counter
// against this lane's duty, applies the lane inversion and registers the
// result, so the output trails the counter value by one clock.
//   clk, rst_n  - clock, asynchronous active-low reset
//   run         - counter is live (enabled, period started, period != 0);
//                 when low the lane sits at its inactive (invert) level
//   cnt         - shared period counter
//   duty        - lane duty D (active while cnt < D)
//   invert      - lane output inversion
//   pwm_out     - registered lane output
module pwm_channel_compare
  import pwm_pkg::*;
#(
  parameter int CNT_W = PWM_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] duty,
  input  logic             invert,
  output logic             pwm_out
);

  logic pwm_d, pwm_q;

  // D = 0 never matches; D >= P always matches since cnt stays below P.
  always_comb begin
    pwm_d = (run && (cnt < duty)) ^ invert;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_q <= 1'b0;
    else        pwm_q <= pwm_d;
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/multi_channel_pwm.sv
// multi_channel_pwm: NUM_CH PWM outputs sharing one prescaled period counter.
// Configuration is double buffered: a load strobe captures the Cfg inputs
// into staging; staging moves into the shadow (live) set at a period
// boundary while running, or on the next clock while disabled.
//   Clk_In, Reset_In       - clock, asynchronous active-low reset
//   PWM_Enable_In          - run the counter when high
//   Cfg_Load_In            - one-cycle strobe capturing all Cfg_* inputs
//   Cfg_Mode_In            - 0 edge-aligned, 1 center-aligned
//   Cfg_Prescale_In        - one tick every Cfg_Prescale_In+1 clocks
//   Cfg_Period_In          - period P in ticks
//   Cfg_Duty_In            - per-channel duty, channel i at [i*CNT_W +: CNT_W]
//   Cfg_Invert_In          - per-channel output inversion
//   Cfg_Busy_Out           - staged config still waiting for the shadow set
//   Period_Start_Out       - one-cycle pulse on the output cycle of counter 0
//   PWM_Signal_Out         - registered PWM outputs
module multi_channel_pwm
  import pwm_pkg::*;
#(
  parameter int NUM_CH = PWM_NUM_CH,
  parameter int CNT_W  = PWM_CNT_W,
  parameter int PRE_W  = PWM_PRE_W
) (
  input  logic                    Clk_In,
  input  logic                    Reset_In,
  input  logic                    PWM_Enable_In,
  input  logic                    Cfg_Load_In,
  input  logic                    Cfg_Mode_In,
  input  logic [PRE_W-1:0]        Cfg_Prescale_In,
  input  logic [CNT_W-1:0]        Cfg_Period_In,
  input  logic [NUM_CH*CNT_W-1:0] Cfg_Duty_In,
  input  logic [NUM_CH-1:0]       Cfg_Invert_In,
  output logic                    Cfg_Busy_Out,
  output logic                    Period_Start_Out,
  output logic [NUM_CH-1:0]       PWM_Signal_Out
);

  // staging set
  pwm_mode_e                    stg_mode_d, stg_mode_q;
  logic [PRE_W-1:0]             stg_pre_d, stg_pre_q;
  logic [CNT_W-1:0]             stg_per_d, stg_per_q;
  logic [NUM_CH-1:0][CNT_W-1:0] stg_duty_d, stg_duty_q;
  logic [NUM_CH-1:0]            stg_inv_d, stg_inv_q;
  logic                         pending_d, pending_q;

  // shadow (live) set
  pwm_mode_e                    sh_mode_d, sh_mode_q;
  logic [PRE_W-1:0]             sh_pre_d, sh_pre_q;
  logic [CNT_W-1:0]             sh_per_d, sh_per_q;
  logic [NUM_CH-1:0][CNT_W-1:0] sh_duty_d, sh_duty_q;
  logic [NUM_CH-1:0]            sh_inv_d, sh_inv_q;

  // timebase
  logic [PRE_W-1:0] pre_cnt_d, pre_cnt_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             dir_d, dir_q;     // center mode: 0 counting up, 1 down
  logic             run_d, run_q;     // a period has started since enable
  logic             bnd_d, bnd_q;     // cnt_q just became 0 at a period start
  logic             start_d, start_q;

  logic tick, wrap, xfer, ch_run;

  // Prescaler and period counter. The first tick after enable is itself a
  // period boundary, so the first period begins with the counter at 0.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    run_d     = run_q;
    tick      = 1'b0;
    wrap      = 1'b0;
    if (!PWM_Enable_In) begin
      pre_cnt_d = '0;
      cnt_d     = '0;
      dir_d     = 1'b0;
      run_d     = 1'b0;
    end else begin
      if (pre_cnt_q >= sh_pre_q) begin
        tick      = 1'b1;
        pre_cnt_d = '0;
      end else begin
        pre_cnt_d = pre_cnt_q + PRE_W'(1);
      end
      if (tick) begin
        if (!run_q || sh_per_q == '0) begin
          wrap = 1'b1;
        end else if (sh_mode_q == PWM_EDGE) begin
          if (cnt_q >= sh_per_q - CNT_W'(1)) wrap = 1'b1;
          else                               cnt_d = cnt_q + CNT_W'(1);
        end else if (!dir_q) begin
          // top value is held for a second tick by turning without moving
          if (cnt_q >= sh_per_q - CNT_W'(1)) dir_d = 1'b1;
          else                               cnt_d = cnt_q + CNT_W'(1);
        end else begin
          // bottom value is held likewise; the turn at 0 is the boundary
          if (cnt_q == '0) wrap = 1'b1;
          else             cnt_d = cnt_q - CNT_W'(1);
        end
        if (wrap) begin
          cnt_d = '0;
          dir_d = 1'b0;
          run_d = 1'b1;
        end
      end
    end
    bnd_d   = wrap;
    start_d = PWM_Enable_In && bnd_q;
  end

  // Staging/shadow handoff. A load coinciding with a transfer still moves
  // the older staging into shadow and leaves the new values pending.
  always_comb begin
    stg_mode_d = stg_mode_q;
    stg_pre_d  = stg_pre_q;
    stg_per_d  = stg_per_q;
    stg_duty_d = stg_duty_q;
    stg_inv_d  = stg_inv_q;
    sh_mode_d  = sh_mode_q;
    sh_pre_d   = sh_pre_q;
    sh_per_d   = sh_per_q;
    sh_duty_d  = sh_duty_q;
    sh_inv_d   = sh_inv_q;
    xfer       = pending_q && (!PWM_Enable_In || wrap);
    if (Cfg_Load_In) begin
      stg_mode_d = pwm_mode_e'(Cfg_Mode_In);
      stg_pre_d  = Cfg_Prescale_In;
      stg_per_d  = Cfg_Period_In;
      stg_duty_d = Cfg_Duty_In;
      stg_inv_d  = Cfg_Invert_In;
    end
    if (xfer) begin
      sh_mode_d = stg_mode_q;
      sh_pre_d  = stg_pre_q;
      sh_per_d  = stg_per_q;
      sh_duty_d = stg_duty_q;
      sh_inv_d  = stg_inv_q;
    end
    pending_d = Cfg_Load_In || (pending_q && !xfer);
  end

  always_ff @(posedge Clk_In or negedge Reset_In) begin
    if (!Reset_In) begin
      stg_mode_q <= PWM_EDGE;
      stg_pre_q  <= '0;
      stg_per_q  <= '0;
      stg_duty_q <= '0;
      stg_inv_q  <= '0;
      pending_q  <= 1'b0;
      sh_mode_q  <= PWM_EDGE;
      sh_pre_q   <= '0;
      sh_per_q   <= '0;
      sh_duty_q  <= '0;
      sh_inv_q   <= '0;
      pre_cnt_q  <= '0;
      cnt_q      <= '0;
      dir_q      <= 1'b0;
      run_q      <= 1'b0;
      bnd_q      <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      stg_mode_q <= stg_mode_d;
      stg_pre_q  <= stg_pre_d;
      stg_per_q  <= stg_per_d;
      stg_duty_q <= stg_duty_d;
      stg_inv_q  <= stg_inv_d;
      pending_q  <= pending_d;
      sh_mode_q  <= sh_mode_d;
      sh_pre_q   <= sh_pre_d;
      sh_per_q   <= sh_per_d;
      sh_duty_q  <= sh_duty_d;
      sh_inv_q   <= sh_inv_d;
      pre_cnt_q  <= pre_cnt_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      run_q      <= run_d;
      bnd_q      <= bnd_d;
      start_q    <= start_d;
    end
  end

  // Enable is used directly so outputs fall to the invert level on the
  // first clock after disable; P = 0 keeps every lane inactive.
  assign ch_run = PWM_Enable_In && run_q && (sh_per_q != '0);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_channel_compare #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk     (Clk_In),
      .rst_n   (Reset_In),
      .run     (ch_run),
      .cnt     (cnt_q),
      .duty    (sh_duty_q[i]),
      .invert  (sh_inv_q[i]),
      .pwm_out (PWM_Signal_Out[i])
    );
  end

  assign Cfg_Busy_Out     = pending_q;
  assign Period_Start_Out = start_q;

endmodule

// File: tb/tb_multi_channel_pwm.sv
// Bench for multi_channel_pwm: directed scenarios plus a randomized phase,
// every clock compared against a tick-count reference model.
module tb_multi_channel_pwm;

  localparam int NCH = 4;
  localparam int CW  = 16;
  localparam int PW  = 8;

  logic                Clk_In, Reset_In, PWM_Enable_In, Cfg_Load_In, Cfg_Mode_In;
  logic [PW-1:0]       Cfg_Prescale_In;
  logic [CW-1:0]       Cfg_Period_In;
  logic [NCH*CW-1:0]   Cfg_Duty_In;
  logic [NCH-1:0]      Cfg_Invert_In;
  logic                Cfg_Busy_Out, Period_Start_Out;
  logic [NCH-1:0]      PWM_Signal_Out;

  multi_channel_pwm #(.NUM_CH(NCH), .CNT_W(CW), .PRE_W(PW)) dut (
    .Clk_In           (Clk_In),
    .Reset_In         (Reset_In),
    .PWM_Enable_In    (PWM_Enable_In),
    .Cfg_Load_In      (Cfg_Load_In),
    .Cfg_Mode_In      (Cfg_Mode_In),
    .Cfg_Prescale_In  (Cfg_Prescale_In),
    .Cfg_Period_In    (Cfg_Period_In),
    .Cfg_Duty_In      (Cfg_Duty_In),
    .Cfg_Invert_In    (Cfg_Invert_In),
    .Cfg_Busy_Out     (Cfg_Busy_Out),
    .Period_Start_Out (Period_Start_Out),
    .PWM_Signal_Out   (PWM_Signal_Out)
  );

  initial Clk_In = 1'b0;
  always #5 Clk_In = ~Clk_In;

  int n_chk, n_pass, cyc, last_start, prev_start;
  int hi[NCH], hi_half[NCH];

  // requested configuration
  int c_mode, c_pre, c_per;
  int c_duty[NCH];
  logic [NCH-1:0] c_inv;

  // reference model
  int m_st_mode, m_st_pre, m_st_per, m_sh_mode, m_sh_pre, m_sh_per;
  int m_st_duty[NCH], m_sh_duty[NCH];
  logic [NCH-1:0] m_st_inv, m_sh_inv;
  bit m_pend, m_run, m_bnd;
  int m_t, m_cnt;
  logic [NCH-1:0] e_pwm;
  logic e_start;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive_cfg();
    Cfg_Mode_In     = c_mode[0];
    Cfg_Prescale_In = PW'(c_pre);
    Cfg_Period_In   = CW'(c_per);
    for (int i = 0; i < NCH; i++) Cfg_Duty_In[i*CW +: CW] = CW'(c_duty[i]);
    Cfg_Invert_In   = c_inv;
  endtask

  task automatic model_reset();
    m_st_mode = 0; m_st_pre = 0; m_st_per = 0; m_st_inv = '0;
    m_sh_mode = 0; m_sh_pre = 0; m_sh_per = 0; m_sh_inv = '0;
    for (int i = 0; i < NCH; i++) begin m_st_duty[i] = 0; m_sh_duty[i] = 0; end
    m_pend = 0; m_run = 0; m_bnd = 0; m_t = 0; m_cnt = 0;
  endtask

  // Counter value derived from ticks elapsed since the period started.
  task automatic model_edge();
    bit en, bnd, xfer;
    int k, len, p1;
    en = PWM_Enable_In;
    for (int c = 0; c < NCH; c++)
      e_pwm[c] = ((en && m_run && m_sh_per != 0 && m_cnt < m_sh_duty[c]) ? 1'b1 : 1'b0) ^ m_sh_inv[c];
    e_start = en && m_bnd;
    bnd = 0;
    p1  = m_sh_pre + 1;
    if (!en) begin
      m_run = 0; m_t = 0; m_cnt = 0;
    end else if (!m_run) begin
      m_t++;
      if (m_t == p1) bnd = 1;
    end else begin
      m_t++;
      if (m_t % p1 == 0) begin
        k   = m_t / p1;
        len = (m_sh_per == 0) ? 1 : (m_sh_mode != 0 ? 2 * m_sh_per : m_sh_per);
        if (k >= len) bnd = 1;
        else m_cnt = (k < m_sh_per) ? k : 2 * m_sh_per - 1 - k;
      end
    end
    if (bnd) begin m_run = 1; m_t = 0; m_cnt = 0; end
    m_bnd = bnd;
    xfer = m_pend && (!en || bnd);
    if (xfer) begin
      m_sh_mode = m_st_mode; m_sh_pre = m_st_pre; m_sh_per = m_st_per; m_sh_inv = m_st_inv;
      for (int i = 0; i < NCH; i++) m_sh_duty[i] = m_st_duty[i];
    end
    if (Cfg_Load_In) begin
      m_st_mode = c_mode; m_st_pre = c_pre; m_st_per = c_per; m_st_inv = c_inv;
      for (int i = 0; i < NCH; i++) m_st_duty[i] = c_duty[i];
    end
    m_pend = Cfg_Load_In || (m_pend && !xfer);
  endtask

  task automatic step(input bit ld);
    @(negedge Clk_In);
    drive_cfg();
    Cfg_Load_In = ld;
    @(posedge Clk_In);
    model_edge();
    #1;
    cyc++;
    Cfg_Load_In = 1'b0;
    chk("pwm", PWM_Signal_Out, e_pwm);
    chk("period_start", Period_Start_Out, e_start);
    chk("busy", Cfg_Busy_Out, m_pend);
  endtask

  task automatic wait_start(input int limit);
    int k;
    k = 0;
    do begin step(1'b0); k++; end while (Period_Start_Out !== 1'b1 && k < limit);
    chk("start_seen", Period_Start_Out, 1);
    prev_start = last_start;
    last_start = cyc;
  endtask

  // Count high output cycles over n samples, the current sample first.
  task automatic measure(input int n, input int ld_at);
    for (int c = 0; c < NCH; c++) begin hi[c] = 0; hi_half[c] = 0; end
    for (int k = 0; k < n; k++) begin
      if (k > 0) step(k == ld_at);
      if (k == ld_at) chk("busy_on_load", Cfg_Busy_Out, 1);
      for (int c = 0; c < NCH; c++)
        if (PWM_Signal_Out[c] === 1'b1) begin
          hi[c]++;
          if (k < n / 2) hi_half[c]++;
        end
    end
  endtask

  task automatic async_reset();
    #1 Reset_In = 1'b0;
    model_reset();
    #1;
    chk("rst_pwm", PWM_Signal_Out, 0);
    chk("rst_start", Period_Start_Out, 0);
    chk("rst_busy", Cfg_Busy_Out, 0);
    #1 Reset_In = 1'b1;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0; last_start = 0; prev_start = 0;
    Reset_In = 1'b1; PWM_Enable_In = 1'b0; Cfg_Load_In = 1'b0;
    c_mode = 0; c_pre = 0; c_per = 0; c_inv = '0;
    for (int i = 0; i < NCH; i++) c_duty[i] = 0;
    drive_cfg();
    #1 Reset_In = 1'b0;
    model_reset();
    #2;
    chk("reset_pwm", PWM_Signal_Out, 0);
    chk("reset_start", Period_Start_Out, 0);
    chk("reset_busy", Cfg_Busy_Out, 0);
    #9 Reset_In = 1'b1;

    // edge mode, P=200, D={150,70,0,255}
    c_per = 200; c_duty[0] = 150; c_duty[1] = 70; c_duty[2] = 0; c_duty[3] = 255;
    step(1'b1);
    chk("busy_staged", Cfg_Busy_Out, 1);
    step(1'b0);
    chk("busy_disabled_xfer", Cfg_Busy_Out, 0);
    PWM_Enable_In = 1'b1;
    wait_start(50);
    measure(200, -1);
    chk("edge_ch0", hi[0], 150);
    chk("edge_ch1", hi[1], 70);
    chk("edge_ch2", hi[2], 0);
    chk("edge_ch3", hi[3], 200);
    wait_start(300);
    chk("edge_spacing", last_start - prev_start, 200);

    // invert channel 0, applied at the next boundary
    c_inv = 4'b0001;
    step(1'b1);
    wait_start(500);
    chk("inv_spacing", last_start - prev_start, 200);
    measure(200, -1);
    chk("inv_ch0", hi[0], 50);
    chk("inv_ch1", hi[1], 70);
    chk("inv_ch3", hi[3], 200);

    // mid-period duty update
    wait_start(300);
    c_duty[1] = 120;
    measure(200, 50);
    chk("upd_ch1_old", hi[1], 70);
    wait_start(300);
    chk("upd_busy_clear", Cfg_Busy_Out, 0);
    measure(200, -1);
    chk("upd_ch1_new", hi[1], 120);

    // center mode P=100, D0=25
    c_mode = 1; c_per = 100; c_duty[0] = 25; c_inv = '0;
    step(1'b1);
    wait_start(500);
    measure(200, -1);
    chk("ctr_ch0", hi[0], 50);
    chk("ctr_ch0_half", hi_half[0], 25);
    wait_start(300);
    chk("ctr_spacing", last_start - prev_start, 200);

    // prescale 3, edge P=200
    c_mode = 0; c_pre = 3; c_per = 200; c_duty[0] = 150;
    step(1'b1);
    wait_start(1000);
    measure(800, -1);
    chk("pre_ch0", hi[0], 600);
    wait_start(1000);
    chk("pre_spacing", last_start - prev_start, 800);

    // randomized configurations, loads and enable toggles
    for (int n = 0; n < 1500; n++) begin
      bit ld;
      if ($urandom_range(99) == 0) PWM_Enable_In = ~PWM_Enable_In;
      ld = ($urandom_range(39) == 0);
      if (ld) begin
        c_mode = int'($urandom_range(1));
        c_pre  = int'($urandom_range(2));
        c_per  = int'($urandom_range(12));
        c_inv  = NCH'($urandom);
        for (int i = 0; i < NCH; i++) c_duty[i] = int'($urandom_range(14));
      end
      step(ld);
    end

    // reset mid-period with a load pending
    PWM_Enable_In = 1'b1;
    c_mode = 0; c_pre = 0; c_per = 50; c_inv = '0;
    step(1'b1);
    wait_start(200);
    repeat (5) step(1'b0);
    c_per = 30;
    step(1'b1);
    step(1'b0);
    async_reset();
    PWM_Enable_In = 1'b0;
    step(1'b0);
    chk("post_rst_busy", Cfg_Busy_Out, 0);
    c_inv = 4'b1010;
    step(1'b1);
    step(1'b0);
    step(1'b0);
    chk("idle_invert", PWM_Signal_Out, 4'b1010);
    PWM_Enable_In = 1'b1;
    wait_start(100);
    repeat (3) step(1'b0);
    PWM_Enable_In = 1'b0;
    step(1'b0);
    chk("disable_invert", PWM_Signal_Out, 4'b1010);
    chk("disable_start", Period_Start_Out, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
